instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the CPU's instruction decoder: accepts symbolic operation requests (op select plus register and immediate fields) and encodes them into 32-bit MIPS instruction words.
- Encoded words are buffered in a small FIFO, then written sequentially into instruction memory through its write port.
- Used by test/boot infrastructure to load programs for the CPU without an external assembler.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 10, instruction-memory word-address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  request valid
- op_ready  out  1  encoder can accept; equals !full
- op_sel  in  4  0 nop, 1 addu, 2 subu, 3 jr, 4 ori, 5 sw, 6 lw, 7 lui, 8 beq, 9 jal, 10 addiu, 11 j; 12–15 illegal
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate
- target  in  26  jump target field
- addr_load  in  1  load write-address counter
- addr_in  in  ADDR_W  value for addr_load
- mem_ready  in  1  memory can take a write this cycle
- im_we  out  1  instruction-memory write enable
- im_addr  out  ADDR_W  word address of current write
- im_wdata  out  32  encoded word at FIFO head
- err_illegal  out  1  sticky: an illegal op_sel was accepted
- words_written  out  16  count of completed writes, saturates at 0xFFFF

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While reset=0:
  - FIFO empty, op_ready=1.
  - im_we=0, im_addr=0, im_wdata=0.
  - err_illegal=0, words_written=0.
  - Asserting reset mid-operation discards all queued words immediately.
- Accept rule: an op is accepted on a rising edge with op_valid && op_ready.
- Encoding of legal ops (opcode[31:26] | rs[25:21] | rt[20:16] | rd[15:11] | shamt[10:6] | funct[5:0]):
  - addu: 000000, rs, rt, rd, 0, 100001
  - subu: 000000, rs, rt, rd, 0, 100011
  - jr: 000000, rs, rt=0, rd=0, 0, 001000
  - nop: 32'h00000000
  - ori: 001101, rs, rt, imm
  - sw: 101011, rs, rt, imm
  - lw: 100011, rs, rt, imm
  - addiu: 001001, rs, rt, imm
  - beq: 000100, rs, rt, imm
  - lui: 001111, rs=0, rt, imm
  - jal: 000011, target
  - j: 000010, target
  - Fields not used by an op are forced to 0, regardless of input values.
- Illegal op_sel:
  - Consumed (handshake completes) but not enqueued.
  - err_illegal sets on that edge and clears only on reset.
- FIFO:
  - Encoded word is written into the FIFO on the accept edge.
  - Read/write pointers wrap modulo DEPTH; a count register distinguishes full from empty.
- Drain:
  - im_we = !empty && mem_ready (combinational from state and mem_ready).
  - im_wdata = FIFO head; it is 0 when empty.
  - On an edge with im_we=1: pop the head, im_addr increments by 1 modulo 2^ADDR_W (wraps 2^ADDR_W−1 → 0), words_written increments (saturating).
- Latency: a word accepted at edge N can appear with im_we=1 in the cycle after edge N, i.e. one cycle later, if the FIFO was empty.
- Simultaneous events:
  - Push and pop on the same edge when not full: both occur, count unchanged.
  - When full: op_ready=0 even if a pop occurs that cycle, so there is no push.
  - addr_load together with a write: the write uses the old im_addr, and the next im_addr = addr_in (load wins over increment).
  - addr_load alone: im_addr = addr_in on the next edge.
- mem_ready=0 stalls draining indefinitely; FIFO contents are preserved.

Test Plan:
- Reset, mem_ready=1, then push in sequence:
  - addu rs=1 rt=2 rd=3 → im_we one cycle later, im_addr=0, im_wdata=0x00221821
  - ori rt=8 imm=0x1234 → 0x34081234 at im_addr=1
  - lui rt=5 imm=0xABCD → 0x3C05ABCD at im_addr=2
- jal target=0x0000C00 → 0x0C000C00; jr rs=31 → 0x03E00008; beq rs=1 rt=2 imm=0xFFFF → 0x1022FFFF; sw rs=29 rt=31 imm=4 → 0xAFBF0004; lui with rs=7 input → still 0x3C05ABCD (rs field forced to 0).
- DEPTH=4, mem_ready=0, present 5 valid ops back-to-back → op_ready drops after the 4th accept and the 5th is held. Raise mem_ready → 4 writes in order on consecutive cycles, then the 5th is accepted and written.
- ADDR_W=4: addr_load with addr_in=15, then push 2 ops → writes at addresses 15 then 0. Assert addr_load=1, addr_in=7 during a write → that write uses the current address, the next write uses 7.
- op_sel=13 with op_valid → accepted, nothing written, err_illegal=1 and it stays 1 through following legal ops.
- Queue 3 words with mem_ready=0, pull reset low mid-cycle → op_ready=1, im_we=0, im_addr=0, words_written=0, err_illegal=0 asynchronously. After release, no stale words are written.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Operation-request bus between a program loader and the instruction encoder.
// Valid/ready handshake carrying the symbolic op select and its operand fields.
interface instr_encoder_if;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] target;

  modport master (
    output op_valid,
    output op_sel,
    output rs,
    output rt,
    output rd,
    output imm,
    output target,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_sel,
    input  rs,
    input  rt,
    input  rd,
    input  imm,
    input  target,
    output op_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS op requests into 32-bit words, buffers them in a small FIFO and
// streams them sequentially into instruction memory through its write port.
module instr_encoder #(
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  instr_encoder_if.slave    op_if,
  input  logic              addr_load_i,
  input  logic [AddrW-1:0]  addr_in_i,
  input  logic              mem_ready_i,
  output logic              im_we_o,
  output logic [AddrW-1:0]  im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              err_illegal_o,
  output logic [15:0]       words_written_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [3:0] SelNop   = 4'd0;
  localparam logic [3:0] SelAddu  = 4'd1;
  localparam logic [3:0] SelSubu  = 4'd2;
  localparam logic [3:0] SelJr    = 4'd3;
  localparam logic [3:0] SelOri   = 4'd4;
  localparam logic [3:0] SelSw    = 4'd5;
  localparam logic [3:0] SelLw    = 4'd6;
  localparam logic [3:0] SelLui   = 4'd7;
  localparam logic [3:0] SelBeq   = 4'd8;
  localparam logic [3:0] SelJal   = 4'd9;
  localparam logic [3:0] SelAddiu = 4'd10;
  localparam logic [3:0] SelJ     = 4'd11;

  localparam logic [5:0] OpcSpecial = 6'b000000;
  localparam logic [5:0] OpcOri     = 6'b001101;
  localparam logic [5:0] OpcSw      = 6'b101011;
  localparam logic [5:0] OpcLw      = 6'b100011;
  localparam logic [5:0] OpcAddiu   = 6'b001001;
  localparam logic [5:0] OpcBeq     = 6'b000100;
  localparam logic [5:0] OpcLui     = 6'b001111;
  localparam logic [5:0] OpcJal     = 6'b000011;
  localparam logic [5:0] OpcJ       = 6'b000010;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnJr   = 6'b001000;

  // FIFO storage and pointers
  logic [31:0]      mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Write-port and status state
  logic [AddrW-1:0] addr_q, addr_d;
  logic             err_q, err_d;
  logic [15:0]      words_q, words_d;

  logic        full, empty;
  logic        accept, legal, push, pop;
  logic [31:0] enc_word;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

  assign op_if.op_ready = ~full;

  assign legal  = (op_if.op_sel <= SelJ);
  assign accept = op_if.op_valid & ~full;
  assign push   = accept & legal;
  assign pop    = ~empty & mem_ready_i;

  // Unused fields of each format are forced to zero, whatever the inputs carry.
  always_comb begin
    enc_word = 32'h0000_0000;
    case (op_if.op_sel)
      SelNop:   enc_word = 32'h0000_0000;
      SelAddu:  enc_word = {OpcSpecial, op_if.rs, op_if.rt, op_if.rd, 5'd0, FnAddu};
      SelSubu:  enc_word = {OpcSpecial, op_if.rs, op_if.rt, op_if.rd, 5'd0, FnSubu};
      SelJr:    enc_word = {OpcSpecial, op_if.rs, 5'd0, 5'd0, 5'd0, FnJr};
      SelOri:   enc_word = {OpcOri, op_if.rs, op_if.rt, op_if.imm};
      SelSw:    enc_word = {OpcSw, op_if.rs, op_if.rt, op_if.imm};
      SelLw:    enc_word = {OpcLw, op_if.rs, op_if.rt, op_if.imm};
      SelLui:   enc_word = {OpcLui, 5'd0, op_if.rt, op_if.imm};
      SelBeq:   enc_word = {OpcBeq, op_if.rs, op_if.rt, op_if.imm};
      SelJal:   enc_word = {OpcJal, op_if.target};
      SelAddiu: enc_word = {OpcAddiu, op_if.rs, op_if.rt, op_if.imm};
      SelJ:     enc_word = {OpcJ, op_if.target};
      default:  enc_word = 32'h0000_0000;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = err_q;
    words_d  = words_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A load overrides the post-write increment; the write itself used the old address.
    if (addr_load_i) begin
      addr_d = addr_in_i;
    end else if (pop) begin
      addr_d = addr_q + 1'b1;
    end

    if (pop && (words_q != 16'hFFFF)) begin
      words_d = words_q + 16'd1;
    end

    if (accept && !legal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      words_q  <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      words_q  <= words_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  assign im_we_o         = pop;
  assign im_addr_o       = addr_q;
  assign im_wdata_o      = empty ? 32'h0000_0000 : mem_q[rd_ptr_q];
  assign err_illegal_o   = err_q;
  assign words_written_o = words_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan steps plus random traffic,
// all compared against a queue-based reference model of the encoder and its write port.
module tb_instr_encoder;

  localparam int unsigned Depth = 4;
  localparam int unsigned AddrW = 4;

  typedef struct packed {
    logic [AddrW-1:0] a;
    logic [31:0]      d;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             addr_load;
  logic [AddrW-1:0] addr_in;
  logic             mem_ready;
  logic             im_we;
  logic [AddrW-1:0] im_addr;
  logic [31:0]      im_wdata;
  logic             err_illegal;
  logic [15:0]      words_written;

  instr_encoder_if op_if ();

  instr_encoder #(
    .Depth (Depth),
    .AddrW (AddrW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .op_if           (op_if),
    .addr_load_i     (addr_load),
    .addr_in_i       (addr_in),
    .mem_ready_i     (mem_ready),
    .im_we_o         (im_we),
    .im_addr_o       (im_addr),
    .im_wdata_o      (im_wdata),
    .err_illegal_o   (err_illegal),
    .words_written_o (words_written)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  logic [31:0] mq[$];
  int unsigned m_addr;
  int unsigned m_words;
  bit          m_err;
  wr_t         obs[$];

  function automatic logic [31:0] ref_encode(input int unsigned op, input int unsigned rs,
                                             input int unsigned rt, input int unsigned rd,
                                             input int unsigned imm, input int unsigned tgt);
    int unsigned r, i, j;
    r = rs << 21;
    i = rt << 16;
    j = rd << 11;
    case (op)
      1:       return r + i + j + 33;
      2:       return r + i + j + 35;
      3:       return r + 8;
      4:       return 32'h3400_0000 + r + i + imm;
      5:       return 32'hAC00_0000 + r + i + imm;
      6:       return 32'h8C00_0000 + r + i + imm;
      7:       return 32'h3C00_0000 + i + imm;
      8:       return 32'h1000_0000 + r + i + imm;
      9:       return 32'h0C00_0000 + tgt;
      10:      return 32'h2400_0000 + r + i + imm;
      11:      return 32'h0800_0000 + tgt;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_addr  = 0;
    m_words = 0;
    m_err   = 0;
  endtask

  task automatic set_op(input bit v, input int unsigned sel, input int unsigned rs,
                        input int unsigned rt, input int unsigned rd, input int unsigned imm,
                        input int unsigned tgt);
    op_if.op_valid = v;
    op_if.op_sel   = sel[3:0];
    op_if.rs       = rs[4:0];
    op_if.rt       = rt[4:0];
    op_if.rd       = rd[4:0];
    op_if.imm      = imm[15:0];
    op_if.target   = tgt[25:0];
  endtask

  // One clock: check outputs mid-cycle, advance the model, then step past the edge.
  task automatic cycle();
    bit          e_rdy, e_we, acc;
    logic [31:0] e_data;
    @(negedge clk);
    e_rdy  = (mq.size() < Depth);
    e_we   = (mq.size() > 0) && mem_ready;
    e_data = (mq.size() > 0) ? mq[0] : 32'h0;
    chk("op_ready", 32'(op_if.op_ready), 32'(e_rdy));
    chk("im_we", 32'(im_we), 32'(e_we));
    chk("im_addr", 32'(im_addr), m_addr % (1 << AddrW));
    chk("im_wdata", im_wdata, e_data);
    chk("err_illegal", 32'(err_illegal), 32'(m_err));
    chk("words_written", 32'(words_written), m_words);
    if (im_we === 1'b1) obs.push_back('{a: im_addr, d: im_wdata});
    acc = op_if.op_valid && e_rdy;
    if (e_we) begin
      void'(mq.pop_front());
      m_addr  = (m_addr + 1) % (1 << AddrW);
      m_words = (m_words == 65535) ? m_words : m_words + 1;
    end
    if (acc && op_if.op_sel <= 11) begin
      mq.push_back(ref_encode(op_if.op_sel, op_if.rs, op_if.rt, op_if.rd, op_if.imm,
                              op_if.target));
    end
    if (acc && op_if.op_sel > 11) m_err = 1;
    if (addr_load) m_addr = addr_in;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_op(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    addr_load = 1'b0;
    addr_in   = '0;
    mem_ready = 1'b1;
    set_op(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic pushes with memory ready
    obs.delete();
    set_op(1, 1, 1, 2, 3, 0, 0);       cycle();
    set_op(1, 4, 0, 8, 0, 16'h1234, 0); cycle();
    set_op(1, 7, 0, 5, 0, 16'hABCD, 0); cycle();
    idle(3);
    chk("basic_count", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("addu_addr", 32'(obs[0].a), 0);
      chk("addu_data", obs[0].d, 32'h0022_1821);
      chk("ori_addr", 32'(obs[1].a), 1);
      chk("ori_data", obs[1].d, 32'h3408_1234);
      chk("lui_addr", 32'(obs[2].a), 2);
      chk("lui_data", obs[2].d, 32'h3C05_ABCD);
    end

    // More encodings, including forced-zero fields
    obs.delete();
    set_op(1, 9, 3, 3, 3, 16'hFFFF, 26'h0000C00); cycle();
    set_op(1, 3, 31, 9, 9, 16'h5555, 0);          cycle();
    set_op(1, 8, 1, 2, 7, 16'hFFFF, 0);           cycle();
    set_op(1, 5, 29, 31, 0, 4, 0);                cycle();
    set_op(1, 7, 7, 5, 9, 16'hABCD, 26'h3FFFFFF); cycle();
    idle(3);
    chk("enc_count", obs.size(), 5);
    if (obs.size() == 5) begin
      chk("jal_data", obs[0].d, 32'h0C00_0C00);
      chk("jr_data", obs[1].d, 32'h03E0_0008);
      chk("beq_data", obs[2].d, 32'h1022_FFFF);
      chk("sw_data", obs[3].d, 32'hAFBF_0004);
      chk("lui_rs_forced", obs[4].d, 32'h3C05_ABCD);
    end

    // Fill to full with memory stalled; fifth request is held
    obs.delete();
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_op(1, 10, k, k + 1, 0, k + 16'h100, 0);
      cycle();
    end
    set_op(1, 2, 6, 7, 8, 0, 0);
    cycle();
    chk("full_ready_low", 32'(op_if.op_ready), 0);
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 1) set_op(0, 0, 0, 0, 0, 0, 0);
    end
    chk("drain_count", obs.size(), 5);
    if (obs.size() == 5) begin
      chk("drain_first", obs[0].d, ref_encode(10, 0, 1, 0, 16'h100, 0));
      chk("drain_fifth", obs[4].d, 32'h00C7_4023);
      chk("drain_consecutive", 32'(obs[3].a) - 32'(obs[0].a), 3);
    end

    // Address load and wrap
    obs.delete();
    addr_load = 1'b1; addr_in = 4'd15;
    cycle();
    addr_load = 1'b0;
    set_op(1, 1, 1, 1, 1, 0, 0); cycle();
    set_op(1, 2, 2, 2, 2, 0, 0); cycle();
    idle(3);
    chk("wrap_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("wrap_addr0", 32'(obs[0].a), 15);
      chk("wrap_addr1", 32'(obs[1].a), 0);
    end

    // Load during a write: that write keeps the old address
    obs.delete();
    mem_ready = 1'b0;
    set_op(1, 4, 1, 2, 0, 16'h0001, 0); cycle();
    set_op(1, 4, 1, 2, 0, 16'h0002, 0); cycle();
    set_op(0, 0, 0, 0, 0, 0, 0);
    mem_ready = 1'b1;
    addr_load = 1'b1; addr_in = 4'd7;
    cycle();
    addr_load = 1'b0;
    idle(2);
    chk("load_wr_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("load_wr_old", 32'(obs[0].a), 1);
      chk("load_wr_new", 32'(obs[1].a), 7);
    end

    // Illegal op: consumed, not written, error sticks
    obs.delete();
    set_op(1, 13, 1, 2, 3, 16'hFFFF, 26'h1);
    cycle();
    idle(2);
    chk("illegal_no_write", obs.size(), 0);
    chk("illegal_err", 32'(err_illegal), 1);
    set_op(1, 1, 4, 5, 6, 0, 0); cycle();
    idle(2);
    chk("err_sticky", 32'(err_illegal), 1);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      set_op($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom, $urandom,
             $urandom, $urandom);
      mem_ready = 1'($urandom_range(0, 1));
      addr_load = ($urandom_range(0, 7) == 0);
      addr_in   = 4'($urandom);
      cycle();
    end
    addr_load = 1'b0;
    mem_ready = 1'b1;
    idle(6);

    // Asynchronous reset with queued words
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_op(1, 6, k, k, 0, k, 0);
      cycle();
    end
    set_op(0, 0, 0, 0, 0, 0, 0);
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(op_if.op_ready), 1);
    chk("rst_we", 32'(im_we), 0);
    chk("rst_addr", 32'(im_addr), 0);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_words", 32'(words_written), 0);
    chk("rst_err", 32'(err_illegal), 0);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs.delete();
    idle(4);
    chk("rst_no_stale", obs.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
